// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions: response codes and the byte-offset width
// derived from the data-bus width.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Number of byte-address bits below the word index.
    function automatic int byte_offs_w(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/axil_skid.sv
// One-entry holding register for an AXI address or data channel.
// The slot is presented downstream while held, or passed straight through.
//
// Handshake (upstream and downstream alike): a beat moves on a rising edge
// only when valid and ready are both high; valid never depends on ready, and
// a producer keeps valid and its payload stable until that edge.
module axil_skid #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    input  logic         i_take
);

    logic         r_full;
    logic [W-1:0] r_data;

    assign o_ready = ~r_full;
    assign o_valid = r_full | i_valid;
    assign o_data  = r_full ? r_data : i_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (i_take) begin
            // Consumed either from the slot or directly from the input.
            r_full <= 1'b0;
        end else if (i_valid && !r_full) begin
            r_full <= 1'b1;
            r_data <= i_data;
        end
    end

endmodule

// File: rtl/s_axil_regfile.sv
// AXI4-Lite slave register file with read-only status registers, per-register
// write strobes and SLVERR for writes to read-only or unimplemented words.
module s_axil_regfile
    import axil_pkg::*;
#(
    parameter int                             DATA_WIDTH = 32,
    parameter int                             ADDR_WIDTH = 4,
    parameter int                             N_REGS     = 12,
    parameter logic [N_REGS-1:0]              RO_MASK    = '0,
    parameter logic [N_REGS*DATA_WIDTH-1:0]   RESET_VAL  = '0,
    localparam int                            OFFS       = byte_offs_w(DATA_WIDTH),
    localparam int                            AW         = ADDR_WIDTH + OFFS,
    localparam int                            SW         = DATA_WIDTH / 8
) (
    input  logic                          axi_clock,
    input  logic                          rst_n,
    input  logic [AW-1:0]                 s_axil_awaddr,
    input  logic [2:0]                    s_axil_awprot,
    input  logic                          s_axil_awvalid,
    output logic                          s_axil_awready,
    input  logic [DATA_WIDTH-1:0]         s_axil_wdata,
    input  logic [SW-1:0]                 s_axil_wstrb,
    input  logic                          s_axil_wvalid,
    output logic                          s_axil_wready,
    output logic [1:0]                    s_axil_bresp,
    output logic                          s_axil_bvalid,
    input  logic                          s_axil_bready,
    input  logic [AW-1:0]                 s_axil_araddr,
    input  logic [2:0]                    s_axil_arprot,
    input  logic                          s_axil_arvalid,
    output logic                          s_axil_arready,
    output logic [DATA_WIDTH-1:0]         s_axil_rdata,
    output logic [1:0]                    s_axil_rresp,
    output logic                          s_axil_rvalid,
    input  logic                          s_axil_rready,
    output logic [N_REGS*DATA_WIDTH-1:0]  reg_out,
    input  logic [N_REGS*DATA_WIDTH-1:0]  hw_in,
    output logic [N_REGS-1:0]             wr_pulse
);

    logic                  w_aw_valid, w_w_valid, w_commit, w_wr_ok, w_rd_hit;
    logic [ADDR_WIDTH-1:0] w_aw_idx, w_ar_idx;
    logic [DATA_WIDTH-1:0] w_wdata, w_rd_data;
    logic [SW-1:0]         w_wstrb;
    logic [N_REGS-1:0]     w_wr_sel;
    logic                  w_unused_ok;

    logic                  r_bvalid, r_rvalid;
    logic [1:0]            r_bresp, r_rresp;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [N_REGS-1:0]     r_wr_pulse;

    axil_skid #(.W(ADDR_WIDTH)) u_aw_skid (
        .clk     (axi_clock),
        .rst_n   (rst_n),
        .i_valid (s_axil_awvalid),
        .o_ready (s_axil_awready),
        .i_data  (s_axil_awaddr[AW-1:OFFS]),
        .o_valid (w_aw_valid),
        .o_data  (w_aw_idx),
        .i_take  (w_commit)
    );

    axil_skid #(.W(DATA_WIDTH + SW)) u_w_skid (
        .clk     (axi_clock),
        .rst_n   (rst_n),
        .i_valid (s_axil_wvalid),
        .o_ready (s_axil_wready),
        .i_data  ({s_axil_wstrb, s_axil_wdata}),
        .o_valid (w_w_valid),
        .o_data  ({w_wstrb, w_wdata}),
        .i_take  (w_commit)
    );

    // A pending response that is not being taken this cycle blocks the commit.
    assign w_commit = w_aw_valid & w_w_valid & ~(r_bvalid & ~s_axil_bready);

    always_comb begin
        w_wr_sel = '0;
        for (int i = 0; i < N_REGS; i++) begin
            if (w_aw_idx == ADDR_WIDTH'(i) && !RO_MASK[i]) w_wr_sel[i] = 1'b1;
        end
    end
    assign w_wr_ok = |w_wr_sel;

    for (genvar g = 0; g < N_REGS; g++) begin : g_reg
        if (RO_MASK[g]) begin : g_ro
            assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = hw_in[g*DATA_WIDTH +: DATA_WIDTH];
        end else begin : g_rw
            logic [DATA_WIDTH-1:0] r_val;
            always_ff @(posedge axi_clock or negedge rst_n) begin
                if (!rst_n) begin
                    r_val <= RESET_VAL[g*DATA_WIDTH +: DATA_WIDTH];
                end else if (w_commit && w_wr_sel[g]) begin
                    for (int b = 0; b < SW; b++) begin
                        if (w_wstrb[b]) r_val[b*8 +: 8] <= w_wdata[b*8 +: 8];
                    end
                end
            end
            assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = r_val;
        end
    end

    always_ff @(posedge axi_clock or negedge rst_n) begin
        if (!rst_n) begin
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
            r_wr_pulse <= '0;
        end else begin
            r_wr_pulse <= w_commit ? w_wr_sel : '0;
            if (w_commit) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
            end else if (s_axil_bready) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    assign w_ar_idx       = s_axil_araddr[AW-1:OFFS];
    assign s_axil_arready = ~(r_rvalid & ~s_axil_rready);

    // reg_out already carries hw_in for read-only words, so one mux serves both.
    always_comb begin
        w_rd_hit  = 1'b0;
        w_rd_data = '0;
        for (int i = 0; i < N_REGS; i++) begin
            if (w_ar_idx == ADDR_WIDTH'(i)) begin
                w_rd_hit  = 1'b1;
                w_rd_data = reg_out[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge axi_clock or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end else if (s_axil_arvalid && s_axil_arready) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_data;
            r_rresp  <= w_rd_hit ? RESP_OKAY : RESP_SLVERR;
        end else if (s_axil_rready) begin
            r_rvalid <= 1'b0;
        end
    end

    assign s_axil_bvalid = r_bvalid;
    assign s_axil_bresp  = r_bresp;
    assign s_axil_rvalid = r_rvalid;
    assign s_axil_rdata  = r_rdata;
    assign s_axil_rresp  = r_rresp;
    assign wr_pulse      = r_wr_pulse;

    assign w_unused_ok = ^{s_axil_awprot, s_axil_arprot, hw_in, s_axil_awaddr, s_axil_araddr};

endmodule

// File: tb/tb_s_axil_regfile.sv
// Self-checking bench for s_axil_regfile: directed scenarios plus randomized
// traffic compared against a word-array model of the register map.
module tb_s_axil_regfile;

    localparam int DW = 32;
    localparam int NR = 12;
    localparam logic [NR-1:0] RO = 12'b0000_0000_1000;

    function automatic logic [NR*DW-1:0] mk_rst();
        logic [NR*DW-1:0] v;
        v = '0;
        v[1*32 +: 32] = 32'h11223344;
        v[3*32 +: 32] = 32'hFFFFFFFF;
        v[5*32 +: 32] = 32'hA5A50005;
        return v;
    endfunction
    localparam logic [NR*DW-1:0] RST_V = mk_rst();

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [5:0]        awaddr = '0, araddr = '0;
    logic [2:0]        awprot = '0, arprot = '0;
    logic              awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
    logic              awready, wready, bvalid, arready, rvalid;
    logic [DW-1:0]     wdata = '0, rdata;
    logic [3:0]        wstrb = '0;
    logic [1:0]        bresp, rresp;
    logic [NR*DW-1:0]  reg_out, hw_in = '0;
    logic [NR-1:0]     wr_pulse;

    s_axil_regfile #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(4), .N_REGS(NR), .RO_MASK(RO), .RESET_VAL(RST_V)
    ) dut (
        .axi_clock(clk), .rst_n(rst_n),
        .s_axil_awaddr(awaddr), .s_axil_awprot(awprot), .s_axil_awvalid(awvalid),
        .s_axil_awready(awready), .s_axil_wdata(wdata), .s_axil_wstrb(wstrb),
        .s_axil_wvalid(wvalid), .s_axil_wready(wready), .s_axil_bresp(bresp),
        .s_axil_bvalid(bvalid), .s_axil_bready(bready), .s_axil_araddr(araddr),
        .s_axil_arprot(arprot), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
        .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid),
        .s_axil_rready(rready), .reg_out(reg_out), .hw_in(hw_in), .wr_pulse(wr_pulse)
    );

    // scoreboard / reference model
    int            n_checks = 0;
    int            n_err = 0;
    logic [DW-1:0] m_regs[NR];
    logic [DW-1:0] hw3;
    logic [33:0]   exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_regs[i] = RST_V[i*32 +: 32];
    endtask

    function automatic logic [33:0] model_read(input logic [5:0] addr);
        int idx;
        idx = int'(addr[5:2]);
        if (idx >= NR) return {2'b10, 32'h0};
        if (idx == 3) return {2'b00, hw3};
        return {2'b00, m_regs[idx]};
    endfunction

    task automatic set_hw(input logic [DW-1:0] v3);
        hw3 = v3;
        for (int i = 0; i < NR; i++) hw_in[i*32 +: 32] = (i == 3) ? v3 : $urandom;
    endtask

    // driver tasks
    task automatic do_write(input logic [5:0] addr, input logic [DW-1:0] data, input logic [3:0] strb);
        logic [1:0]    eresp;
        logic [NR-1:0] epulse;
        int            idx, n;
        bit            aw_done, w_done;
        idx = int'(addr[5:2]);
        if (idx < NR && idx != 3) begin
            for (int b = 0; b < 4; b++) if (strb[b]) m_regs[idx][b*8 +: 8] = data[b*8 +: 8];
            eresp  = 2'b00;
            epulse = NR'(1) << idx;
        end else begin
            eresp  = 2'b10;
            epulse = '0;
        end
        @(negedge clk);
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1; wvalid = 1; bready = 1;
        aw_done = 0; w_done = 0; n = 0;
        while (!(aw_done && w_done) && n < 20) begin
            #1;
            if (awvalid && awready) aw_done = 1;
            if (wvalid && wready) w_done = 1;
            @(negedge clk);
            n++;
            if (aw_done) awvalid = 0;
            if (w_done) wvalid = 0;
        end
        awvalid = 0; wvalid = 0;
        n = 0;
        while (!bvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("wr_bvalid_seen", bvalid, 1);
        check("wr_bresp", bresp, eresp);
        check("wr_pulse", wr_pulse, epulse);
        @(negedge clk);
        check("wr_bvalid_clr", bvalid, 0);
        check("wr_pulse_clr", wr_pulse, 0);
    endtask

    task automatic do_read(input logic [5:0] addr, output logic [DW-1:0] got);
        logic [33:0] e;
        int          n;
        @(negedge clk);
        araddr = addr; arvalid = 1; rready = 1;
        n = 0;
        #1;
        while (!arready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        e = model_read(addr);
        @(negedge clk);
        arvalid = 0;
        got = rdata;
        check("rd_rvalid", rvalid, 1);
        check("rd_rdata", rdata, e[31:0]);
        check("rd_rresp", rresp, e[33:32]);
        @(negedge clk);
        check("rd_rvalid_clr", rvalid, 0);
    endtask

    logic [DW-1:0] d, old6, d1, d2;
    logic [1:0]    bresp_hold;
    logic [33:0]   e, hold;
    logic [5:0]    b2b_addr[4];
    int            issued, got_n, n;
    bit            stall;

    initial begin
        model_reset();
        set_hw(32'h0000CAFE);
        repeat (3) @(posedge clk);
        #1;
        check("rst_bvalid", bvalid, 0);
        check("rst_rvalid", rvalid, 0);
        @(negedge clk);
        rst_n = 1;
        #1;
        check("rst_awready", awready, 1);
        check("rst_wready", wready, 1);
        check("rst_arready", arready, 1);
        check("rst_bresp", bresp, 0);
        check("rst_rresp", rresp, 0);
        check("rst_rdata", rdata, 0);
        check("rst_wr_pulse", wr_pulse, 0);
        for (int i = 0; i < NR; i++)
            check("rst_reg_out", reg_out[i*32 +: 32], (i == 3) ? hw3 : m_regs[i]);

        // basic write / read
        do_write(6'h08, 32'hDEADBEEF, 4'hF);
        do_read(6'h08, d);
        check("deadbeef_const", d, 32'hDEADBEEF);

        // byte strobes on the preloaded register
        do_write(6'h04, 32'hAABBCCDD, 4'h5);
        do_read(6'h04, d);
        check("strobe_const", d, 32'h11BB33DD);

        // W ahead of AW, then a second write stalled behind an unaccepted B
        d1 = $urandom; d2 = $urandom;
        @(negedge clk);
        bready = 0; wvalid = 1; wdata = d1; wstrb = 4'hF;
        @(negedge clk);
        wvalid = 0;
        check("wfirst_wready_low", wready, 0);
        check("wfirst_no_b", bvalid, 0);
        repeat (2) @(negedge clk);
        awaddr = 6'h10; awvalid = 1;
        @(negedge clk);
        awvalid = 0;
        m_regs[4] = d1;
        check("wfirst_bvalid", bvalid, 1);
        check("wfirst_bresp", bresp, 0);
        check("wfirst_pulse", wr_pulse, NR'(1) << 4);
        check("wfirst_awready_back", awready, 1);
        check("wfirst_wready_back", wready, 1);
        bresp_hold = bresp;
        awaddr = 6'h14; awvalid = 1; wdata = d2; wvalid = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            awvalid = 0; wvalid = 0;
            check("stall_bvalid", bvalid, 1);
            check("stall_bresp", bresp, bresp_hold);
            check("stall_awready", awready, 0);
            check("stall_wready", wready, 0);
            check("stall_no_pulse", wr_pulse, 0);
        end
        bready = 1;
        @(negedge clk);
        m_regs[5] = d2;
        check("release_bvalid", bvalid, 1);
        check("release_pulse", wr_pulse, NR'(1) << 5);
        check("release_awready", awready, 1);
        check("release_wready", wready, 1);
        @(negedge clk);
        check("release_bvalid_clr", bvalid, 0);
        check("release_pulse_clr", wr_pulse, 0);
        do_read(6'h10, d);
        do_read(6'h14, d);

        // read-only register and unimplemented words
        do_write(6'h0C, 32'h12345678, 4'hF);
        do_read(6'h0C, d);
        check("ro_const", d, 32'h0000CAFE);
        set_hw(32'h0BADF00D);
        #1;
        check("ro_mirror", reg_out[3*32 +: 32], 32'h0BADF00D);
        do_read(6'h3C, d);
        do_write(6'h3C, 32'hFFFFFFFF, 4'hF);

        // read and write of the same word in one cycle
        old6 = m_regs[6]; d = ~old6;
        @(negedge clk);
        awaddr = 6'h18; awvalid = 1; wdata = d; wstrb = 4'hF; wvalid = 1; bready = 1;
        araddr = 6'h18; arvalid = 1; rready = 1;
        @(negedge clk);
        awvalid = 0; wvalid = 0; arvalid = 0;
        m_regs[6] = d;
        check("same_rvalid", rvalid, 1);
        check("same_old_value", rdata, old6);
        check("same_bvalid", bvalid, 1);
        check("same_pulse", wr_pulse, NR'(1) << 6);
        @(negedge clk);
        check("same_bvalid_clr", bvalid, 0);

        // back-to-back reads with a wobbling rready
        b2b_addr = '{6'h08, 6'h3C, 6'h04, 6'h0C};
        issued = 0; got_n = 0; stall = 0; n = 0;
        while (got_n < 4 && n < 60) begin
            @(negedge clk);
            rready = 1'($urandom_range(0, 1));
            arvalid = (issued < 4);
            if (issued < 4) araddr = b2b_addr[issued];
            #1;
            if (rvalid) begin
                if (stall) check("b2b_hold", {rresp, rdata}, hold);
                if (rready) begin
                    if (exp_q.size() == 0) begin
                        check("b2b_extra", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("b2b_data", {rresp, rdata}, e);
                    end
                    got_n++;
                    stall = 0;
                end else begin
                    stall = 1;
                    hold = {rresp, rdata};
                end
            end
            if (arvalid && arready) begin
                exp_q.push_back(model_read(araddr));
                issued++;
            end
            n++;
        end
        @(negedge clk);
        arvalid = 0; rready = 1;
        check("b2b_count", got_n, 4);
        check("b2b_no_extra", rvalid, 0);

        // randomized traffic
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 1) == 0) begin
                do_write({4'($urandom_range(0, 15)), 2'b00}, $urandom, 4'($urandom_range(0, 15)));
            end else begin
                set_hw($urandom);
                do_read({4'($urandom_range(0, 15)), 2'b00}, d);
            end
        end
        for (int i = 0; i < NR; i++) check("rand_reg_out", reg_out[i*32 +: 32], (i == 3) ? hw3 : m_regs[i]);

        // reset with B and R pending plus a write sitting in the holding slots
        @(negedge clk);
        bready = 0; rready = 0;
        awaddr = 6'h08; wdata = 32'h55; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        araddr = 6'h04; arvalid = 1;
        @(negedge clk);
        arvalid = 0;
        check("pre_rst_bvalid", bvalid, 1);
        check("pre_rst_rvalid", rvalid, 1);
        awaddr = 6'h14;
        @(negedge clk);
        awvalid = 0; wvalid = 0;
        rst_n = 0;
        #1;
        check("mid_rst_bvalid", bvalid, 0);
        check("mid_rst_rvalid", rvalid, 0);
        check("mid_rst_rdata", rdata, 0);
        check("mid_rst_awready", awready, 1);
        check("mid_rst_wready", wready, 1);
        check("mid_rst_arready", arready, 1);
        check("mid_rst_reg2", reg_out[2*32 +: 32], RST_V[2*32 +: 32]);
        repeat (2) @(negedge clk);
        rst_n = 1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("post_rst_bvalid", bvalid, 0);
            check("post_rst_rvalid", rvalid, 0);
            check("post_rst_pulse", wr_pulse, 0);
        end
        for (int i = 0; i < NR; i++) do_read(6'(i * 4), d);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/s_axil_regfile.md
Name: s_axil_regfile

Overview:
- Parametrised AXI4-Lite slave register file; next generation of the block-RAM-style AXI register bank.
- Generalises data width and register count, and adds read-only (hardware-fed) registers, per-register write pulses and SLVERR responses for illegal accesses.
- Sits between the PS/AXI interconnect and fabric control/status logic.
- Register contents are exported flat so any fabric block can use them directly.

Parameters:
- DATA_WIDTH, 32, register and AXI data width; multiple of 8, from 8 to 64.
- ADDR_WIDTH, 4, word-address bits. AXI byte address width is AW = ADDR_WIDTH + $clog2(DATA_WIDTH/8).
- N_REGS, 12, number of implemented registers; must be ≤ 2**ADDR_WIDTH.
- RO_MASK, {N_REGS{1'b0}}, bit i = 1 makes register i read-only, sourced from hw_in.
- RESET_VAL, {N_REGS*DATA_WIDTH{1'b0}}, flat reset value of the writable registers.

Ports:
- axi_clock  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- s_axil_awaddr  in  AW  write byte address; the low $clog2(DATA_WIDTH/8) bits are ignored.
- s_axil_awprot  in  3  ignored.
- s_axil_awvalid  in  1 / s_axil_awready  out  1.
- s_axil_wdata  in  DATA_WIDTH / s_axil_wstrb  in  DATA_WIDTH/8.
- s_axil_wvalid  in  1 / s_axil_wready  out  1.
- s_axil_bresp  out  2 / s_axil_bvalid  out  1 / s_axil_bready  in  1.
- s_axil_araddr  in  AW / s_axil_arprot  in  3 (ignored).
- s_axil_arvalid  in  1 / s_axil_arready  out  1.
- s_axil_rdata  out  DATA_WIDTH / s_axil_rresp  out  2.
- s_axil_rvalid  out  1 / s_axil_rready  in  1.
- reg_out  out  N_REGS*DATA_WIDTH  current register values; register i is at slice [i*DATA_WIDTH +: DATA_WIDTH].
- hw_in  in  N_REGS*DATA_WIDTH  status inputs; only slices with RO_MASK=1 are used.
- wr_pulse  out  N_REGS  one-cycle strobe in the cycle after a successful write to register i.

Behaviour:
- Reset (async assert, sync deassert is the system's job):
  - awready=wready=arready=1; bvalid=rvalid=0; bresp=rresp=0; rdata=0; wr_pulse=0.
  - Writable registers load RESET_VAL.
- Write channel:
  - AW and W are accepted independently.
  - Each has a one-entry holding register; its ready drops after acceptance until the write commits.
  - Commit happens in the cycle where both the address and data are held (or presented with valid&ready), and B is not stalled. Stalled means bvalid=1 & bready=0.
  - At commit: bvalid<=1 on the next edge; both readys reassert on the next edge.
  - Max throughput is one write per cycle when bready is held high.
- Write decode at commit (word index idx):
  - idx < N_REGS and RO_MASK[idx]=0: update the bytes whose wstrb bit is set; bresp=OKAY(00); wr_pulse[idx]=1 for exactly one cycle. This applies even if wstrb=0.
  - idx ≥ N_REGS or read-only: no state change; bresp=SLVERR(10); no pulse.
- B channel:
  - bvalid is held until bready.
  - A new commit is blocked while B is stalled; a commit may occur in the same cycle that bready clears the pending response.
  - bresp is stable while bvalid=1.
- Read channel:
  - Latency is one cycle: the AR handshake at edge n gives rvalid=1 after edge n, with rdata registered.
  - arready = !(rvalid & !rready), so there is one outstanding read.
  - Back-to-back reads run at one per cycle when rready=1.
  - rdata/rresp are held stable while rvalid & !rready.
- Read decode:
  - idx < N_REGS: rdata = RO_MASK[idx] ? hw_in slice (sampled at the AR handshake) : register value; rresp=OKAY.
  - idx ≥ N_REGS: rdata=0, rresp=SLVERR.
- Simultaneous read and write to the same register in one cycle: the read returns the pre-write value.
- Read-only slices of reg_out mirror hw_in combinationally.
- Reset mid-transaction: all in-flight transactions are dropped; no B/R response is issued after reset.

Decomposition:
- Shared package axil_pkg:
  - Response constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
  - Function clog2-based byte-offset width helper.
- Sub-module axil_skid (one-entry holding register with valid/ready), instantiated for AW and W.
- Register array, decode and R path are in the top module.

Test Plan:
- Write 0xDEADBEEF to addr 0x08 with wstrb=0xF, then read 0x08 → bresp=00, wr_pulse[2] high for 1 cycle, rdata=0xDEADBEEF, rresp=00.
- Byte strobes: reg 1 preloaded 0x11223344, write 0xAABBCCDD with wstrb=0x5 → read returns 0x11BB33DD.
- W presented 3 cycles before AW, with bready held low 4 cycles → one commit only, bvalid held with bresp stable, awready/wready low until release, second write accepted the cycle bready rises.
- RO_MASK[3]=1, hw_in[3]=0x0000CAFE: write 0x12345678 to 0x0C → bresp=10, no wr_pulse; read 0x0C → 0x0000CAFE.
- Reads of addr 0x3C (idx 15 ≥ N_REGS=12) → rresp=10, rdata=0. 4 back-to-back reads with rready toggling → each returned once, in order, with no data change while stalled.
- Assert rst_n=0 while bvalid=1 and rvalid=1 → outputs return to their reset values immediately, and registers read RESET_VAL after release.
